// File: rtl/data_memory_banked_pkg.sv
// Shared encodings for the banked data memory: access sizes, FSM states and
// the wait-state counter width.
package data_memory_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/data_memory_banked_if.sv
// Request/response bus between the MEM stage (master) and the data memory (slave).
interface data_memory_banked_if #(
  parameter int unsigned ADDR_W = 13
);

  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              unsigned_ld;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              rvalid;
  logic              ready;
  logic              misaligned;

  modport master (
    output req, we, size, unsigned_ld, addr, wdata,
    input  rdata, rvalid, ready, misaligned
  );

  modport slave (
    input  req, we, size, unsigned_ld, addr, wdata,
    output rdata, rvalid, ready, misaligned
  );

endinterface

// File: rtl/data_memory_banked_mem_lane_align.sv
// Combinational lane logic: alignment check, byte enables, store-data
// replication and load extraction with sign/zero extension.
module mem_lane_align
  import data_memory_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        unsigned_ld,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic        aligned,
  output logic [3:0]  be,
  output logic [31:0] wlanes,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  assign shifted = rword >> {lane, 3'b000};

  always_comb begin
    aligned = 1'b0;
    be      = '0;
    wlanes  = '0;
    case (size)
      SZ_BYTE: begin
        aligned = 1'b1;
        be      = 4'b0001 << lane;
        wlanes  = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        aligned = ~lane[0];
        be      = 4'b0011 << lane;
        wlanes  = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        aligned = (lane == 2'b00);
        be      = '1;
        wlanes  = wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    rdata_ext = rword;
    case (size)
      SZ_BYTE: rdata_ext = {{24{~unsigned_ld & shifted[7]}}, shifted[7:0]};
      SZ_HALF: rdata_ext = {{16{~unsigned_ld & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_banked.sv
// Byte-addressed little-endian data memory with configurable wait states,
// a ready/rvalid handshake and misaligned-access rejection.
module data_memory_banked
  import data_memory_pkg::*;
#(
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter int unsigned LATENCY     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  data_memory_banked_if.slave  bus
);

  localparam int unsigned       IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0]  LAT   = CNT_W'(LATENCY);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               we_q;
  logic [1:0]         size_q;
  logic               unsigned_q;
  logic [IDX_W+1:0]   addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic               rvalid_q;
  logic               ready_q;
  logic               mis_q;

  logic [31:0]        mem [DEPTH_WORDS];

  logic               busy;
  logic               commit;
  logic [IDX_W-1:0]   idx;
  logic [1:0]         al_size;
  logic [1:0]         al_lane;
  logic               al_unsigned;
  logic [31:0]        al_wdata;
  logic               aligned;
  logic [3:0]         be;
  logic [31:0]        wlanes;
  logic [31:0]        rdata_ext;

  assign busy   = (state == ST_BUSY);
  assign commit = busy && (cnt == '0);
  assign idx    = addr_q[IDX_W+1:2];

  // One aligner serves both phases: live request fields while idle (alignment
  // check), latched fields while busy (enables, replication, extraction).
  assign al_size     = busy ? size_q     : bus.size;
  assign al_lane     = busy ? addr_q[1:0] : bus.addr[1:0];
  assign al_unsigned = busy ? unsigned_q : bus.unsigned_ld;
  assign al_wdata    = busy ? wdata_q    : bus.wdata;

  mem_lane_align u_align (
    .size        (al_size),
    .lane        (al_lane),
    .unsigned_ld (al_unsigned),
    .wdata       (al_wdata),
    .rword       (mem[idx]),
    .aligned     (aligned),
    .be          (be),
    .wlanes      (wlanes),
    .rdata_ext   (rdata_ext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      ready_q    <= 1'b1;
      mis_q      <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      mis_q    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            if (aligned) begin
              we_q       <= bus.we;
              size_q     <= bus.size;
              unsigned_q <= bus.unsigned_ld;
              addr_q     <= bus.addr[IDX_W+1:0];
              wdata_q    <= bus.wdata;
              cnt        <= LAT;
              state      <= ST_BUSY;
              ready_q    <= 1'b0;
            end else begin
              mis_q <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state    <= ST_IDLE;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b1;
            if (!we_q) rdata_q <= rdata_ext;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Array is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (commit && we_q) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
      end
    end
  end

  assign bus.rdata      = rdata_q;
  assign bus.rvalid     = rvalid_q;
  assign bus.ready      = ready_q;
  assign bus.misaligned = mis_q;

endmodule

// File: tb/tb_data_memory_banked.sv
// Directed bench for data_memory_banked: three instances cover LATENCY=1,
// LATENCY=3 (reset mid-access) and DEPTH_WORDS=16/LATENCY=0 (wrap, throughput).
module tb_data_memory_banked;
  import data_memory_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst;
  logic [2:0]  req_v, we_v, uns_v;
  logic [1:0]  size_v [3];
  logic [12:0] addr_v [3];
  logic [31:0] wdata_v [3];
  logic [31:0] rdata_o [3];
  logic [2:0]  rvalid_o, ready_o, mis_o;

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 1 : (g == 1) ? 3 : 0;
    localparam int unsigned DEP = (g == 2) ? 16 : 2048;
    data_memory_banked_if #(.ADDR_W(13)) bus ();
    data_memory_banked #(.ADDR_W(13), .DEPTH_WORDS(DEP), .LATENCY(LAT)) u_dut (
      .clk   (clk),
      .reset (rst[g]),
      .bus   (bus)
    );
    assign bus.req         = req_v[g];
    assign bus.we          = we_v[g];
    assign bus.size        = size_v[g];
    assign bus.unsigned_ld = uns_v[g];
    assign bus.addr        = addr_v[g];
    assign bus.wdata       = wdata_v[g];
    assign rdata_o[g]      = bus.rdata;
    assign rvalid_o[g]     = bus.rvalid;
    assign ready_o[g]      = bus.ready;
    assign mis_o[g]        = bus.misaligned;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one request; returns #1 after the accepting edge with req dropped.
  task automatic issue(input int d, input logic w, input logic [1:0] sz, input logic uns,
                       input logic [12:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_v[d] = 1'b1; we_v[d] = w; size_v[d] = sz; uns_v[d] = uns;
    addr_v[d] = a; wdata_v[d] = wd;
    @(posedge clk); #1;
    req_v[d] = 1'b0;
  endtask

  task automatic xfer(input int d, input string tag, input logic w, input logic [1:0] sz,
                      input logic uns, input logic [12:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output int busy);
    logic rv;
    issue(d, w, sz, uns, a, wd);
    busy = 0;
    rv   = 1'b0;
    for (int i = 0; i < 16 && !rv; i++) begin
      if (rvalid_o[d]) rv = 1'b1;
      else begin
        if (!ready_o[d]) busy++;
        @(posedge clk); #1;
      end
    end
    chk({tag, "_rvalid"}, {31'd0, rv}, 32'd1);
    rd = rdata_o[d];
  endtask

  task automatic mis_case(input int d, input string tag, input logic w, input logic [1:0] sz,
                          input logic [12:0] a, input logic [31:0] wd);
    issue(d, w, sz, 1'b0, a, wd);
    chk({tag, "_mis"},    {31'd0, mis_o[d]},    32'd1);
    chk({tag, "_ready"},  {31'd0, ready_o[d]},  32'd1);
    chk({tag, "_rvalid"}, {31'd0, rvalid_o[d]}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_mis_end"},   {31'd0, mis_o[d]},    32'd0);
    chk({tag, "_rvalid_nx"}, {31'd0, rvalid_o[d]}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    int          busy;
    int          nvalid;
    logic        prev;
    logic        consec;

    rst = '1; req_v = '0; we_v = '0; uns_v = '0;
    for (int i = 0; i < 3; i++) begin
      size_v[i] = SZ_WORD; addr_v[i] = '0; wdata_v[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata",  rdata_o[0], 32'h0);
    chk("rst_ready",  {31'd0, ready_o[0]}, 32'd1);
    chk("rst_rvalid", {31'd0, rvalid_o[0]}, 32'd0);
    chk("rst_mis",    {31'd0, mis_o[0]}, 32'd0);
    @(negedge clk);
    rst = '0;

    // LATENCY=1: word store/load, two ready-low cycles each
    xfer(0, "st_w10", 1'b1, SZ_WORD, 1'b0, 13'h010, 32'h12345678, rd, busy);
    chk("st_w10_busy", busy, 32'd2);
    xfer(0, "ld_w10", 1'b0, SZ_WORD, 1'b0, 13'h010, 32'h0, rd, busy);
    chk("ld_w10_busy", busy, 32'd2);
    chk("ld_w10", rd, 32'h12345678);

    // byte store into lane 1, loads with both extensions
    xfer(0, "clr10",  1'b1, SZ_WORD, 1'b0, 13'h010, 32'h0, rd, busy);
    xfer(0, "st_b11", 1'b1, SZ_BYTE, 1'b0, 13'h011, 32'hFFFFFFAB, rd, busy);
    xfer(0, "ld_w10b", 1'b0, SZ_WORD, 1'b0, 13'h010, 32'h0, rd, busy);
    chk("ld_w10b", rd, 32'h0000AB00);
    xfer(0, "ld_sb11", 1'b0, SZ_BYTE, 1'b0, 13'h011, 32'h0, rd, busy);
    chk("ld_sb11", rd, 32'hFFFFFFAB);
    xfer(0, "ld_ub11", 1'b0, SZ_BYTE, 1'b1, 13'h011, 32'h0, rd, busy);
    chk("ld_ub11", rd, 32'h000000AB);
    xfer(0, "ld_ub13", 1'b0, SZ_BYTE, 1'b1, 13'h013, 32'h0, rd, busy);
    chk("ld_ub13", rd, 32'h00000000);
    xfer(0, "ld_sh10", 1'b0, SZ_HALF, 1'b0, 13'h010, 32'h0, rd, busy);
    chk("ld_sh10", rd, 32'hFFFFAB00);

    // upper-half store leaves lanes 0-1 alone
    xfer(0, "st_w20",  1'b1, SZ_WORD, 1'b0, 13'h020, 32'h11112222, rd, busy);
    xfer(0, "st_h22",  1'b1, SZ_HALF, 1'b0, 13'h022, 32'h00008001, rd, busy);
    xfer(0, "ld_sh22", 1'b0, SZ_HALF, 1'b0, 13'h022, 32'h0, rd, busy);
    chk("ld_sh22", rd, 32'hFFFF8001);
    xfer(0, "ld_uh22", 1'b0, SZ_HALF, 1'b1, 13'h022, 32'h0, rd, busy);
    chk("ld_uh22", rd, 32'h00008001);
    xfer(0, "ld_w20", 1'b0, SZ_WORD, 1'b1, 13'h020, 32'h0, rd, busy);
    chk("ld_w20", rd, 32'h80012222);

    // rdata holds across a store
    xfer(0, "st_b20", 1'b1, SZ_BYTE, 1'b0, 13'h020, 32'h00000055, rd, busy);
    chk("hold_rdata", rd, 32'h80012222);
    xfer(0, "ld_w20b", 1'b0, SZ_WORD, 1'b0, 13'h020, 32'h0, rd, busy);
    chk("ld_w20b", rd, 32'h80012255);

    // misaligned requests are rejected without touching memory
    xfer(0, "clr14", 1'b1, SZ_WORD, 1'b0, 13'h014, 32'h0, rd, busy);
    mis_case(0, "mis_w13",  1'b0, SZ_WORD, 13'h013, 32'h0);
    mis_case(0, "mis_h15",  1'b1, SZ_HALF, 13'h015, 32'hFFFFFFFF);
    mis_case(0, "mis_sz11", 1'b1, 2'b11,   13'h010, 32'hFFFFFFFF);
    xfer(0, "ld_w14", 1'b0, SZ_WORD, 1'b0, 13'h014, 32'h0, rd, busy);
    chk("ld_w14", rd, 32'h00000000);
    xfer(0, "ld_w10c", 1'b0, SZ_WORD, 1'b0, 13'h010, 32'h0, rd, busy);
    chk("ld_w10c", rd, 32'h0000AB00);

    // LATENCY=3: reset in the middle of a store aborts it
    xfer(1, "l3_st40", 1'b1, SZ_WORD, 1'b0, 13'h040, 32'h11223344, rd, busy);
    chk("l3_st40_busy", busy, 32'd4);
    xfer(1, "l3_ld40", 1'b0, SZ_WORD, 1'b0, 13'h040, 32'h0, rd, busy);
    chk("l3_ld40", rd, 32'h11223344);
    issue(1, 1'b1, SZ_WORD, 1'b0, 13'h040, 32'hDEADBEEF);
    chk("l3_busy_ready", {31'd0, ready_o[1]}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b1;
    #1;
    chk("l3_rst_ready",  {31'd0, ready_o[1]}, 32'd1);
    chk("l3_rst_rvalid", {31'd0, rvalid_o[1]}, 32'd0);
    chk("l3_rst_mis",    {31'd0, mis_o[1]}, 32'd0);
    chk("l3_rst_rdata",  rdata_o[1], 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("l3_rst_no_rvalid", {31'd0, rvalid_o[1]}, 32'd0);
    @(negedge clk);
    rst[1] = 1'b0;
    xfer(1, "l3_ld40b", 1'b0, SZ_WORD, 1'b0, 13'h040, 32'h0, rd, busy);
    chk("l3_ld40_after_rst", rd, 32'h11223344);

    // DEPTH_WORDS=16, LATENCY=0: index wraps, one access per two cycles
    xfer(2, "wr_st40", 1'b1, SZ_WORD, 1'b0, 13'h040, 32'hCAFEF00D, rd, busy);
    chk("wr_st40_busy", busy, 32'd1);
    xfer(2, "wr_ld00", 1'b0, SZ_WORD, 1'b0, 13'h000, 32'h0, rd, busy);
    chk("wr_ld00", rd, 32'hCAFEF00D);
    @(negedge clk);
    req_v[2] = 1'b1; we_v[2] = 1'b0; size_v[2] = SZ_WORD; uns_v[2] = 1'b0; addr_v[2] = 13'h000;
    nvalid = 0; prev = 1'b0; consec = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rvalid_o[2]) nvalid++;
      if (rvalid_o[2] && prev) consec = 1'b1;
      prev = rvalid_o[2];
    end
    @(negedge clk);
    req_v[2] = 1'b0;
    chk("b2b_count", nvalid, 32'd5);
    chk("b2b_no_consec", {31'd0, consec}, 32'd0);
    chk("b2b_rdata", rdata_o[2], 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory_banked.md
Name: data_memory_banked

Overview:
- Parametrised successor to the single-word pipeline data memory.
- Byte-addressed and little-endian; supports byte, half and word stores and loads, with sign or zero extension on loads.
- Adds a configurable wait-state count with a ready/rvalid handshake, so the MEM stage can stall.
- Flags misaligned accesses for the hazard/exception logic.

Parameters:
- ADDR_W, 13, byte-address width.
- DEPTH_WORDS, 2048, number of 32-bit words stored; must be a power of 2 and ≤ 2^(ADDR_W-2).
- LATENCY, 1, extra wait cycles per access; range 0..7.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  access request; sampled only when ready=1.
- we  in  1  1=store, 0=load; qualified by req.
- size  in  2  00=byte, 01=half, 10=word, 11=illegal (treated as misaligned).
- unsigned_ld  in  1  load zero-extends when 1, sign-extends when 0.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- rdata  out  32  load result, registered.
- rvalid  out  1  one-cycle pulse: rdata valid (loads) or store committed (stores).
- ready  out  1  1=able to accept req this cycle.
- misaligned  out  1  one-cycle pulse on a rejected request.

Behaviour:
- Reset, asynchronous: state=IDLE, counter=0, rdata=0, rvalid=0, ready=1, misaligned=0.
- Memory array is not cleared by reset; contents are retained.
- States:
  - IDLE: ready=1.
  - BUSY: ready=0.
- Request acceptance (req=1 and ready=1 at edge E0):
  - Alignment check: half requires addr[0]=0; word requires addr[1:0]=0; size=11 always fails.
  - Misaligned: misaligned=1 for the cycle after E0; no memory access; state stays IDLE; rvalid stays 0.
  - Aligned: latch we/size/unsigned_ld/addr/wdata; counter←LATENCY; state←BUSY.
- BUSY:
  - If counter≠0: counter decrements each edge.
  - At the edge where counter==0: perform the access; state←IDLE; rvalid=1 for the following cycle.
  - Total latency is LATENCY+1 edges from acceptance to commit. LATENCY=0 gives commit at E1 and rvalid high in the cycle after E1.
- Word index = addr[ADDR_W-1:2] modulo DEPTH_WORDS; out-of-range addresses wrap with no error.
- Lane = addr[1:0].
- Store:
  - Byte writes lane [8*lane+7:8*lane] from wdata[7:0].
  - Half writes lanes lane and lane+1 from wdata[15:0].
  - Word writes all four lanes.
  - Unselected lanes are unchanged.
- Load:
  - Extract the selected lane(s).
  - Extend to 32 bits per unsigned_ld; word loads ignore unsigned_ld.
  - rdata updates only on load commit and holds its value otherwise, including across stores.
- req while ready=0 is ignored, not queued; the requester holds req until ready.
- Back-to-back requests: ready rises in the same cycle rvalid pulses, so a new req may be accepted at that edge. Sustained throughput is one access per LATENCY+2 cycles.
- Reset mid-BUSY: access aborted; a store not yet committed leaves memory unchanged; rvalid is not asserted.
- Write and read never coincide, because one access is in flight at a time.

Decomposition:
- Package data_memory_pkg holds:
  - Size encodings: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - State encodings: ST_IDLE, ST_BUSY.
  - Counter width constant: 3.
- One sub-module, mem_lane_align (combinational), holds the alignment check, byte-enable generation, store data replication across lanes, and load extraction/extension.
- The top level holds the FSM, counter, array and registers.

Test Plan:
- LATENCY=1: store word 32'h12345678 at addr 0x010, then load word at 0x010 → ready low 2 cycles per access; rvalid each time; rdata=32'h12345678.
- Store byte 8'hAB at 0x011 over word 0x00000000 at 0x010 → word load gives 32'h0000AB00. Signed byte load at 0x011 gives 32'hFFFFFFAB. Unsigned byte load gives 32'h000000AB.
- Half store 16'h8001 at 0x022 → signed half load 0x022=32'hFFFF8001; unsigned=32'h00008001. Lanes 0-1 of word 0x020 are unchanged.
- Misaligned: word load at 0x013, half store at 0x015, size=11 → misaligned pulse 1 cycle each; ready stays 1; memory unchanged; rvalid never asserted.
- Reset asserted mid-BUSY of a store of 32'hDEADBEEF at 0x040 with LATENCY=3 → outputs return to reset values immediately; a later load at 0x040 returns the prior value.
- Wrap and throughput: DEPTH_WORDS=16, store at 0x040 → read back at 0x000. Back-to-back req with LATENCY=0 → one rvalid every 2 cycles.
